// File: rtl/bus_share_arbiter.sv
`default_nettype none
// ============================================================================
// bus_share_arbiter : two-requester round-robin owner of the 16-bit mux E/S
// Rev 1.0
// ============================================================================
module bus_share_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CW        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          mux_e,
  output logic          mux_s,
  output logic [CW-1:0] burst_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_MAX = CW'(MAX_BURST);

  state_t        state;
  state_t        state_nxt;
  state_t        other;
  logic          prio;
  logic          prio_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          req_me;
  logic          req_other;
  logic          lock_me;
  logic          at_max;

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    cnt_nxt   = burst_cnt;
    other     = (state == OWN1) ? OWN0 : OWN1;
    req_me    = (state == OWN1) ? req1  : req0;
    req_other = (state == OWN1) ? req0  : req1;
    lock_me   = (state == OWN1) ? lock1 : lock0;
    at_max    = (burst_cnt >= C_MAX);

    case (state)
      IDLE: begin
        // prio=1 means requester 1 wins a tie
        if (req0 && (!req1 || !prio)) state_nxt = OWN0;
        else if (req1)                state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (!req_me)                                state_nxt = req_other ? other : IDLE;
        else if (req_other && at_max && !lock_me)   state_nxt = other;
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == IDLE) begin
      cnt_nxt = '0;
    end else if (state_nxt != state) begin
      cnt_nxt  = CW'(1);
      prio_nxt = (state_nxt == OWN0);
    end else begin
      cnt_nxt = at_max ? C_MAX : burst_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      burst_cnt <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      mux_e     <= 1'b0;
      mux_s     <= 1'b0;
    end else begin
      state     <= state_nxt;
      prio      <= prio_nxt;
      burst_cnt <= cnt_nxt;
      gnt0      <= (state_nxt == OWN0);
      gnt1      <= (state_nxt == OWN1);
      mux_e     <= (state_nxt != IDLE);
      mux_s     <= (state_nxt == OWN1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_bus_share_arbiter : scoreboard bench, MAX_BURST=4 and MAX_BURST=1 copies
// Rev 1.0
// ============================================================================
module tb_bus_share_arbiter;

  localparam int CW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0  = 1'b0;
  logic          req1  = 1'b0;
  logic          lock0 = 1'b0;
  logic          lock1 = 1'b0;
  logic          ga0, ga1, ea, sa;
  logic [CW-1:0] ca;
  logic          gb0, gb1, eb, sb_s;
  logic [CW-1:0] cb;

  always #5 clk = ~clk;

  bus_share_arbiter #(.MAX_BURST(4), .CW(CW)) dut_a (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .gnt0(ga0), .gnt1(ga1), .mux_e(ea), .mux_s(sa), .burst_cnt(ca)
  );

  bus_share_arbiter #(.MAX_BURST(1), .CW(CW)) dut_b (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .gnt0(gb0), .gnt1(gb1), .mux_e(eb), .mux_s(sb_s), .burst_cnt(cb)
  );

  // owner: -1 idle, else requester index; held: cycles owned so far
  typedef struct packed { int owner; int held; int prio; } model_t;
  typedef struct packed { logic [7:0] a; logic [7:0] b; } exp_t;

  exp_t   sb[$];
  model_t ma, mb;
  int     tests = 0;
  int     fails = 0;

  localparam model_t M_IDLE = '{owner: -1, held: 0, prio: 0};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic model_t take(input model_t m, input int who);
    m.owner = who;
    m.held  = 1;
    m.prio  = 1 - who;
    return m;
  endfunction

  function automatic model_t step(input model_t m, input bit r0, input bit r1,
                                  input bit l0, input bit l1, input int maxb);
    bit [1:0] r;
    bit [1:0] l;
    int       me;
    int       ot;
    r = {r1, r0};
    l = {l1, l0};
    if (m.owner < 0) begin
      if (r0 && r1)  m = take(m, m.prio);
      else if (r0)   m = take(m, 0);
      else if (r1)   m = take(m, 1);
    end else begin
      me = m.owner;
      ot = 1 - me;
      if (!r[me]) begin
        if (r[ot]) m = take(m, ot);
        else begin
          m.owner = -1;
          m.held  = 0;
        end
      end else if (r[ot] && m.held >= maxb && !l[me]) begin
        m = take(m, ot);
      end else if (m.held < maxb) begin
        m.held++;
      end
    end
    return m;
  endfunction

  function automatic logic [7:0] enc(input model_t m);
    logic g0;
    logic g1;
    g0 = (m.owner == 0);
    g1 = (m.owner == 1);
    return {g0, g1, g0 | g1, g1, 4'(m.held)};
  endfunction

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    ma = M_IDLE;
    mb = M_IDLE;
    sb.push_back({enc(ma), enc(mb)});
    #1;
    check("async_reset_a", {ga0, ga1, ea, sa, ca}, 8'h00);
    check("async_reset_b", {gb0, gb1, eb, sb_s, cb}, 8'h00);
  endtask

  task automatic cyc(input bit r0, input bit r1, input bit l0, input bit l1);
    @(posedge clk); #2;
    rst_n = 1'b1;
    req0  = r0;
    req1  = r1;
    lock0 = l0;
    lock1 = l1;
    ma = step(ma, r0, r1, l0, l1, 4);
    mb = step(mb, r0, r1, l0, l1, 1);
    sb.push_back({enc(ma), enc(mb)});
  endtask

  // monitor: outputs of edge N are compared at N+1, expectations pushed at N-1+2
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      check("excl_a", {7'd0, ga0 & ga1}, 8'h00);
      check("excl_b", {7'd0, gb0 & gb1}, 8'h00);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_a", {ga0, ga1, ea, sa, ca}, e.a);
        check("out_b", {gb0, gb1, eb, sb_s, cb}, e.b);
      end
    end
  end

  initial begin
    bit r0, r1, l0, l1;
    r0 = 1'b0; r1 = 1'b0; l0 = 1'b0; l1 = 1'b0;
    ma = M_IDLE;
    mb = M_IDLE;

    do_reset();
    repeat (3) cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);

    repeat (12) cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);

    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);

    cyc(1, 0, 1, 0);
    repeat (10) cyc(1, 1, 1, 0);
    repeat (3) cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);

    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    do_reset();
    repeat (4) cyc(1, 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 5) == 0)  r0 = ~r0;
        if ($urandom_range(0, 5) == 0)  r1 = ~r1;
        if ($urandom_range(0, 11) == 0) l0 = ~l0;
        if ($urandom_range(0, 11) == 0) l1 = ~l1;
        cyc(r0, r1, l0, l1);
      end
    end

    repeat (2) @(posedge clk);
    #3;
    check("drain", 8'(sb.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
